uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised successor to the team's fixed 8N1 UART transmitter.
- Adds: configurable data width; runtime parity (none/even/odd); 1 or 2 stop bits; 8-entry baud table; input FIFO with valid/ready handshake for back-to-back frames.
- Sits between the system bus/controller and the board TX pin; single clock domain.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; used to derive the baud divisors.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, input buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- baud_sel  in  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
- parity_mode  in  2  00=none, 01=even, 10=odd, 11=none.
- two_stop  in  1  1 = two stop bits, 0 = one.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  DATA_BITS  word to transmit.
- in_ready  out  1  FIFO can accept a word (= fifo_count != FIFO_DEPTH).
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently buffered.
- busy  out  1  FSM not in IDLE.
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- tx  out  1  serial line, idle high.

Behaviour:
- One clock; reset is synchronous and active-high. On any edge with rst=1: tx=1, busy=0, tx_done=0, fifo_count=0 (so in_ready=1), FSM=IDLE, FIFO pointers cleared. A frame in flight at reset is abandoned; tx is high after that edge.
- Baud divisor: DIV[sel] = CLK_FREQ / baud, integer floor, computed at elaboration. At 50 MHz: sel4=434, sel7=54. Each serial bit lasts exactly DIV clock cycles.
- FIFO write: occurs when in_valid && in_ready. The write is blocked when full even if a pop happens the same cycle. Simultaneous push and pop when not full leaves fifo_count unchanged. Data is popped in order.
- Config latch: baud_sel, parity_mode and two_stop are latched together with the word at pop. Changing them mid-frame affects only later frames.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if fifo_count != 0, pop the word, drive tx<=0 and go to START at that edge. A word written at edge N into an empty FIFO with the FSM idle is popped at edge N+1, so tx falls after edge N+1.
- START: tx=0 for DIV cycles, then go to DATA.
- DATA: LSB first, DATA_BITS bits of DIV cycles each. Then go to PARITY if parity is enabled, else STOP.
- PARITY: one bit. Even = XOR of the data bits; odd = inverted XOR.
- STOP: tx=1 for DIV cycles, or 2*DIV cycles if two_stop was latched.
- End of STOP: tx_done=1 for that one cycle. If the FIFO is non-empty, pop and go straight to START (tx<=0), with no idle gap; otherwise go to IDLE.
- Frame length is exactly (1 + DATA_BITS + P + S) * DIV cycles, with P in {0,1} and S in {1,2}.
- busy=1 in all states except IDLE.

Test Plan:
- Reset, then push 0x55 with sel=4, no parity, 1 stop -> tx falls 1 cycle after acceptance; bit sequence 0,1,0,1,0,1,0,1,0,1; each bit 434 cycles; tx_done after 4340 cycles; busy low the next cycle.
- Push 0xAA with sel=7, even parity, two_stop=1 -> bits 0, 0,1,0,1,0,1,0,1, parity 0, stop 1,1; 54 cycles/bit; 648-cycle frame.
- Push 0xEF with sel=7, odd parity -> parity bit 0; with even parity instead -> parity bit 1.
- Hold in_valid for 6 consecutive words while idle, FIFO_DEPTH=4 -> 5 words accepted, in_ready low from the 6th cycle, fifo_count=4; frames go back-to-back with no gap between stop and start; the 6th word is accepted the cycle after the first tx_done.
- Change baud_sel from 4 to 7 mid-frame -> the current frame keeps 434-cycle bits; the next frame uses 54.
- Assert rst mid-DATA with 2 words buffered -> tx=1 and busy=0 after that edge; fifo_count=0; no tx_done pulse; no further frames sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and per-frame configuration: baud, parity, stop bits.
// The configuration is captured together with each word at pop, so changes made mid-frame apply only to later frames.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2:0]                       baud_sel,
  input  logic [1:0]                       parity_mode,
  input  logic                             two_stop,
  input  logic                             in_valid,
  input  logic [DATA_BITS-1:0]             in_data,
  output logic                             in_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             busy,
  output logic                             tx_done,
  output logic                             tx
);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int DIV_W = $clog2(CLK_FREQ / 9600 + 1);
  localparam int BW    = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // Every branch returns an elaboration-time constant, so no divider is built.
  function automatic logic [DIV_W-1:0] div_of(input logic [2:0] sel);
    case (sel)
      3'd0:    return DIV_W'(CLK_FREQ / 9600);
      3'd1:    return DIV_W'(CLK_FREQ / 19200);
      3'd2:    return DIV_W'(CLK_FREQ / 38400);
      3'd3:    return DIV_W'(CLK_FREQ / 57600);
      3'd4:    return DIV_W'(CLK_FREQ / 115200);
      3'd5:    return DIV_W'(CLK_FREQ / 230400);
      3'd6:    return DIV_W'(CLK_FREQ / 460800);
      default: return DIV_W'(CLK_FREQ / 921600);
    endcase
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d, two_stop_q, two_stop_d;
  logic                 par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d, busy_q, busy_d, tx_done_q, tx_done_d;
  logic                 bit_end, load;

  assign in_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign tx         = tx_q;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    two_stop_d = two_stop_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    data_d     = data_q;
    tx_d       = tx_q;
    load       = 1'b0;
    bit_end    = (cnt_q == div_q - DIV_W'(1));

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      IDLE:  load = (count_q != '0);
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? par_bit_q : 1'b1;
          stop_d  = 1'b0;
        end else begin
          bit_d  = bit_q + BW'(1);
          data_d = data_q >> 1;
          tx_d   = data_q[1];
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
        stop_d  = 1'b0;
      end
      STOP: if (bit_end) begin
        if (stop_q == two_stop_q) begin
          load    = (count_q != '0);
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop straight into START, both from IDLE and from the end of STOP, so frames run back-to-back.
    if (load) begin
      state_d    = START;
      tx_d       = 1'b0;
      cnt_d      = '0;
      data_d     = mem_q[rd_ptr_q];
      div_d      = div_of(baud_sel);
      two_stop_d = two_stop;
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d  = (^mem_q[rd_ptr_q]) ^ (parity_mode == 2'b10);
    end
    pop = load;

    busy_d    = (state_d != IDLE);
    tx_done_d = (state_d == STOP) && (cnt_d == div_d - DIV_W'(1)) && (stop_d == two_stop_d);

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // NOTE: state is updated only with non-blocking assignments, so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      two_stop_q <= two_stop_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based line model compared every cycle,
// plus directed frames with hand-computed bit sequences and timings.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ   = 50000000;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           baud_sel = 3'd4;
  logic [1:0]           parity_mode = 2'b00;
  logic                 two_stop = 1'b0;
  logic                 in_valid = 1'b0;
  logic [DATA_BITS-1:0] in_data = '0;
  logic                 in_ready, busy, tx_done, tx;
  logic [CW-1:0]        fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .baud_sel(baud_sel), .parity_mode(parity_mode), .two_stop(two_stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .fifo_count(fifo_count),
    .busy(busy), .tx_done(tx_done), .tx(tx)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a FIFO of words and a queue of line levels, one entry per clock cycle of the frame.
  int unsigned          baud_tab [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
  logic [DATA_BITS-1:0] m_fifo [$];
  bit                   m_line [$];
  bit                   armed = 1'b0;
  bit                   m_acc;
  int                   m_div;
  logic [DATA_BITS-1:0] m_w;

  task automatic add_bit(input bit b, input int div);
    for (int k = 0; k < div; k++) m_line.push_back(b);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_fifo.delete();
      m_line.delete();
      armed = 1'b1;
    end else begin
      m_acc = in_valid && (m_fifo.size() != FIFO_DEPTH);
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_fifo.size() > 0) begin
        m_w   = m_fifo.pop_front();
        m_div = CLK_FREQ / baud_tab[baud_sel];
        add_bit(1'b0, m_div);
        for (int i = 0; i < DATA_BITS; i++) add_bit(m_w[i], m_div);
        if (parity_mode == 2'b01) add_bit(^m_w, m_div);
        else if (parity_mode == 2'b10) add_bit(~^m_w, m_div);
        add_bit(1'b1, m_div);
        if (two_stop) add_bit(1'b1, m_div);
      end
      if (m_acc) m_fifo.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("cmp_tx", 32'(tx), (m_line.size() > 0) ? 32'(m_line[0]) : 32'd1);
      check("cmp_busy", 32'(busy), 32'(m_line.size() > 0));
      check("cmp_done", 32'(tx_done), 32'(m_line.size() == 1));
      check("cmp_count", 32'(fifo_count), 32'(m_fifo.size()));
      check("cmp_ready", 32'(in_ready), 32'(m_fifo.size() != FIFO_DEPTH));
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || fifo_count != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < budget), 32'd1);
  endtask

  // Push one word into an idle, empty transmitter and pin the one-cycle start latency.
  task automatic push_and_start(input string name, input logic [DATA_BITS-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_pre"}, 32'(tx), 32'd1);
    @(negedge clk);
    check({name, "_fall"}, 32'(tx), 32'd0);
  endtask

  // Called on the first cycle of a start bit; samples each bit mid-way and pins the tx_done cycle.
  task automatic run_frame(input string name, input logic [15:0] bits, input int nbits,
                           input int div, input int chg_at);
    int last = nbits * div - 1;
    for (int c = 0; c <= last; c++) begin
      if (c % div == div / 2) check({name, "_bit"}, 32'(tx), 32'(bits[c / div]));
      if (c == chg_at) baud_sel = 3'd7;
      if (c == last - 1) check({name, "_done_early"}, 32'(tx_done), 32'd0);
      if (c == last) check({name, "_done"}, 32'(tx_done), 32'd1);
      if (c != last) @(negedge clk);
    end
  endtask

  logic [DATA_BITS-1:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    int idx, n, done_n, acc5_n;
    bit quiet;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x55 at 115200, 8N1: 10 bits of 434 cycles.
    push_and_start("t1", 8'h55);
    run_frame("t1", {6'd0, 1'b1, 8'h55, 1'b0}, 10, 434, -1);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);

    // 0xAA at 921600, even parity, two stop bits: 12 bits of 54 cycles = 648.
    baud_sel = 3'd7; parity_mode = 2'b01; two_stop = 1'b1;
    push_and_start("t2", 8'hAA);
    run_frame("t2", {4'd0, 2'b11, 1'b0, 8'hAA, 1'b0}, 12, 54, -1);
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'd0);

    // 0xEF has seven ones: odd parity bit 0, even parity bit 1.
    two_stop = 1'b0; parity_mode = 2'b10;
    push_and_start("t3o", 8'hEF);
    run_frame("t3o", {5'd0, 1'b1, 1'b0, 8'hEF, 1'b0}, 11, 54, -1);
    wait_idle(200);
    parity_mode = 2'b01;
    push_and_start("t3e", 8'hEF);
    run_frame("t3e", {5'd0, 1'b1, 1'b1, 8'hEF, 1'b0}, 11, 54, -1);
    wait_idle(200);

    // Six words offered back-to-back into a depth-4 FIFO.
    parity_mode = 2'b00;
    idx = 0; n = 0; done_n = -1; acc5_n = -1;
    while (idx < 6 && n < 3000) begin
      in_valid = 1'b1;
      in_data  = words[idx];
      if (n == 5) begin
        check("t4_full_count", 32'(fifo_count), 32'd4);
        check("t4_full_ready", 32'(in_ready), 32'd0);
        check("t4_accepted", 32'(idx), 32'd5);
      end
      if (tx_done && done_n < 0) begin
        done_n = n;
        check("t4_ready_at_done", 32'(in_ready), 32'd0);
      end
      if (in_ready) begin
        if (idx == 5) acc5_n = n;
        idx++;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("t4_sixth_after_done", 32'(acc5_n), 32'(done_n + 1));
    check("t4_no_gap", 32'(tx), 32'd0);
    wait_idle(5000);

    // Baud change mid-frame affects only the following frame.
    baud_sel = 3'd4;
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_data = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_fall", 32'(tx), 32'd0);
    run_frame("t5a", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 434, 1000);
    @(negedge clk);
    run_frame("t5b", {6'd0, 1'b1, 8'hC3, 1'b0}, 10, 54, -1);
    wait_idle(200);

    // Reset in the middle of DATA with two words buffered.
    in_valid = 1'b1; in_data = 8'hA1;
    @(negedge clk);
    in_data = 8'hB2;
    @(negedge clk);
    in_data = 8'hC4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (54 * 3) @(negedge clk);
    check("t6_buffered", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_tx", 32'(tx), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_done", 32'(tx_done), 32'd0);
    quiet = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      if (!tx || tx_done || busy) quiet = 1'b0;
    end
    check("t6_quiet", 32'(quiet), 32'd1);

    // Random traffic, configuration changes and rare resets, checked by the per-cycle model.
    for (int c = 0; c < 15000; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = DATA_BITS'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        baud_sel    = 3'($urandom_range(6, 7));
        parity_mode = 2'($urandom);
        two_stop    = 1'($urandom);
      end
      rst = ($urandom_range(0, 4999) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    wait_idle(10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
